// File: rtl/hazard_pkg.sv
// Shared types and default stall lengths for the pipeline hazard controller.
// Optional statistics are enabled by defining HAZARD_CTRL_STATS_EN.
package hazard_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_FWD  = 2'd1,
        SRC_LU   = 2'd2,
        SRC_SW   = 2'd3
    } src_e;

    localparam int REG_AW_DEF    = 5;
    localparam int CNT_W_DEF     = 4;
    localparam int LU_STALL_DEF  = 2;
    localparam int SW_STALL_DEF  = 1;
    localparam int FWD_STALL_DEF = 3;
    localparam int STAT_W        = 16;

endpackage

// File: rtl/hazard_req_sel.sv
// Combinational hazard detection and priority encoder: picks the winning
// stall source (fwd > load-use > store) and its clamped stall length.
module hazard_req_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW    = REG_AW_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int LU_STALL  = LU_STALL_DEF,
    parameter int SW_STALL  = SW_STALL_DEF,
    parameter int FWD_STALL = FWD_STALL_DEF
) (
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_memwrite,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              fwd_stall,
    output src_e              source,
    output logic [CNT_W-1:0]  length
);

    localparam int MAX_LEN = (1 << CNT_W) - 1;

    function automatic logic [CNT_W-1:0] clamp_len(input int len);
        if (len <= 0) begin
            return '0;
        end else if (len > MAX_LEN) begin
            return CNT_W'(MAX_LEN);
        end else begin
            return CNT_W'(len);
        end
    endfunction

    localparam logic [CNT_W-1:0] LU_LEN  = clamp_len(LU_STALL);
    localparam logic [CNT_W-1:0] SW_LEN  = clamp_len(SW_STALL);
    localparam logic [CNT_W-1:0] FWD_LEN = clamp_len(FWD_STALL);

    if (LU_STALL > MAX_LEN || SW_STALL > MAX_LEN || FWD_STALL > MAX_LEN) begin : g_len_check
        $error("hazard_req_sel: stall length exceeds 2^CNT_W-1");
    end

    logic match;
    logic fwd_req;
    logic lu_req;
    logic sw_req;

    // Register 0 is hardwired, so a write to it can never create a dependency.
    assign match   = (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign fwd_req = fwd_stall && (FWD_LEN != '0);
    assign lu_req  = ex_memread && match && (LU_LEN != '0);
    assign sw_req  = ex_memwrite && match && !id_memwrite && (SW_LEN != '0);

    always_comb begin
        source = SRC_NONE;
        length = '0;
        if (fwd_req) begin
            source = SRC_FWD;
            length = FWD_LEN;
        end else if (lu_req) begin
            source = SRC_LU;
            length = LU_LEN;
        end else if (sw_req) begin
            source = SRC_SW;
            length = SW_LEN;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: holds PC/IF-ID and injects ID/EX bubbles for a
// fixed per-source number of cycles. Define HAZARD_CTRL_STATS_EN for counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW    = REG_AW_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int LU_STALL  = LU_STALL_DEF,
    parameter int SW_STALL  = SW_STALL_DEF,
    parameter int FWD_STALL = FWD_STALL_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_memwrite,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              fwd_stall,
    input  logic              flush,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              stall_select,
    output logic              stall_active
`ifdef HAZARD_CTRL_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_lu,
    output logic [STAT_W-1:0] stat_sw,
    output logic [STAT_W-1:0] stat_fwd
`endif
);

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  remain_q;
    logic [CNT_W-1:0]  remain_d;
    src_e              req_src;
    logic [CNT_W-1:0]  req_len;
    logic              enter_stall;

    hazard_req_sel #(
        .REG_AW    (REG_AW),
        .CNT_W     (CNT_W),
        .LU_STALL  (LU_STALL),
        .SW_STALL  (SW_STALL),
        .FWD_STALL (FWD_STALL)
    ) u_req_sel (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_memwrite (id_memwrite),
        .ex_memread  (ex_memread),
        .ex_memwrite (ex_memwrite),
        .ex_rt       (ex_rt),
        .fwd_stall   (fwd_stall),
        .source      (req_src),
        .length      (req_len)
    );

    assign enter_stall = (state_q == IDLE) && !flush && (req_src != SRC_NONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    // Requests seen while already stalling are dropped, never queued.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        if (flush) begin
            state_d  = IDLE;
            remain_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_src != SRC_NONE) begin
                        state_d  = STALL;
                        remain_d = req_len;
                    end
                end
                STALL: begin
                    if (remain_q <= CNT_W'(1)) begin
                        state_d  = IDLE;
                        remain_d = '0;
                    end else begin
                        remain_d = remain_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d  = IDLE;
                    remain_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        pc_write     = (state_q == IDLE);
        if_id_write  = (state_q == IDLE);
        stall_select = (state_q == IDLE);
        stall_active = (state_q == STALL);
    end

`ifdef HAZARD_CTRL_STATS_EN
    // Saturating event counters, one bump per IDLE->STALL entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lu  <= '0;
            stat_sw  <= '0;
            stat_fwd <= '0;
        end else if (enter_stall) begin
            if (req_src == SRC_LU && stat_lu != {STAT_W{1'b1}}) begin
                stat_lu <= stat_lu + STAT_W'(1);
            end
            if (req_src == SRC_SW && stat_sw != {STAT_W{1'b1}}) begin
                stat_sw <= stat_sw + STAT_W'(1);
            end
            if (req_src == SRC_FWD && stat_fwd != {STAT_W{1'b1}}) begin
                stat_fwd <= stat_fwd + STAT_W'(1);
            end
        end
    end
`else
    logic unused_enter;
    assign unused_enter = enter_stall;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter CNT_W, default 4, stall-counter width.
REQ-003 Parameter LU_STALL, default 2, load-use stall length in cycles; 0 disables this source.
REQ-004 Parameter SW_STALL, default 1, store-after-use stall length in cycles; 0 disables this source.
REQ-005 Parameter FWD_STALL, default 3, forwarding-unit stall length in cycles; 0 disables this source.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous and active-low.
REQ-008 id_rs, id_rt  in  REG_AW each  source registers of the instruction in ID.
REQ-009 id_memwrite  in  1  the instruction in ID is a store.
REQ-010 ex_memread, ex_memwrite  in  1 each  the instruction in EX is a load / store.
REQ-011 ex_rt  in  REG_AW  destination (rt) of the instruction in EX.
REQ-012 fwd_stall  in  1  stall request from the forwarding unit.
REQ-013 flush  in  1  taken branch/jump; aborts any stall.
REQ-014 pc_write, if_id_write  out  1 each  1 = normal update, 0 = hold.
REQ-015 stall_select  out  1  1 = pass control, 0 = inject bubble into ID/EX.
REQ-016 stall_active  out  1  high while in state STALL.

Function
REQ-017 Match rule: ex_rt equals id_rs or ex_rt equals id_rt, with ex_rt != 0; register 0 never causes a hazard.
REQ-018 Load-use request: ex_memread && match.
REQ-019 Store request: ex_memwrite && match && !id_memwrite.
REQ-020 Priority when more than one request is valid on the same edge: fwd_stall, then load-use, then store; the selected length is FWD_STALL, LU_STALL or SW_STALL respectively.
REQ-021 A request whose length parameter is 0 is treated as absent, and the next-priority request is selected.
REQ-022 States: IDLE and STALL; remain_q is a CNT_W-bit down-counter.
REQ-023 IDLE -> STALL on an edge where a selected request exists and flush=0; on that edge remain_q <= the selected length.
REQ-024 In STALL, remain_q decrements each edge; STALL -> IDLE on the edge where remain_q==1.
REQ-025 Outputs are decoded from state only: IDLE gives pc_write = if_id_write = stall_select = 1; STALL gives all three 0.
REQ-026 The outputs are therefore low for exactly N consecutive cycles, starting the cycle after detection.
REQ-027 New requests arriving while in STALL are ignored; there is no extension and no queueing.
REQ-028 flush=1 in any state forces IDLE and remain_q=0 on the next edge; flush has priority over every request.
REQ-029 Stall lengths are clamped to 2^CNT_W-1; the counter never wraps.
REQ-030 Elaboration fails if any length parameter exceeds 2^CNT_W-1.

Reset
REQ-031 While rst_n=0: state=IDLE, remain_q=0, pc_write=1, if_id_write=1, stall_select=1, stall_active=0, and all statistics counters are 0.
REQ-032 Reset asserted during a stall aborts it immediately, without waiting for a clock edge.

Configuration
REQ-033 Macro HAZARD_CTRL_STATS_EN.
REQ-034 When HAZARD_CTRL_STATS_EN is defined, the block adds three 16-bit saturating outputs: stat_lu, stat_sw and stat_fwd.
REQ-035 Each statistics counter increments on every IDLE->STALL entry for its source and holds at 16'hFFFF.
REQ-036 When HAZARD_CTRL_STATS_EN is undefined, those ports and counters are absent and behaviour is otherwise identical.

Structure
REQ-037 Package hazard_pkg holds: the state enum (IDLE, STALL), the source enum (SRC_NONE, SRC_FWD, SRC_LU, SRC_SW), and the default length constants.
REQ-038 The combinational request/priority encoder is a sub-module, hazard_req_sel, with outputs source and length.

Verification
REQ-039 Load-use: ex_memread=1, ex_rt=5, id_rs=5, defaults -> pc_write is 0 for exactly 2 cycles, then returns to 1.
REQ-040 Register zero: ex_memread=1, ex_rt=0, id_rt=0 -> no stall; outputs stay 1.
REQ-041 Simultaneous requests: fwd_stall=1 and a load-use match on the same edge -> 3-cycle stall; stat_fwd=1 and stat_lu=0 when HAZARD_CTRL_STATS_EN is defined.
REQ-042 Flush mid-operation: flush=1 in the second cycle of a 3-cycle fwd stall -> IDLE on the next edge, with outputs 1.
REQ-043 Reset mid-operation: rst_n=0 asynchronously mid-stall -> outputs 1 immediately; no stall resumes after release.
REQ-044 Disabled source: SW_STALL=0 with ex_memwrite=1 and a match -> no stall.
